// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program-store / run controller:
// state and command encodings, the JMP opcode and default widths.
package prog_seq_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int CYC_W_DEF  = 8;

   localparam logic [3:0] OP_JMP = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      CMD_CLEAR = 2'b00,
      CMD_RUN   = 2'b01,
      CMD_STEP  = 2'b10,
      CMD_STOP  = 2'b11
   } cmd_t;

endpackage

// File: rtl/prog_seq_ctrl_prog_store.sv
// Program store: 2**ADDR_W x DATA_W flop array, cleared by reset,
// synchronous write, asynchronous read.
module prog_store #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Clear every word on reset; otherwise capture accepted writes.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_seq_ctrl.sv
// Program-store and run controller for the 4-bit accumulator CPU.
// Serves instructions, gates CPU progress via cpu_en (run/step/stop),
// auto-halts on a self-jump and counts executed instructions.
// Optional breakpoint support is compiled in with PROG_SEQ_BREAKPOINT_EN.
module prog_seq_ctrl
   import prog_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CYC_W  = CYC_W_DEF
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_en,
   output logic [1:0]        state,
   output logic              halted,
   output logic [CYC_W-1:0]  cyc_cnt
`ifdef PROG_SEQ_BREAKPOINT_EN
   ,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr
`endif
);

   state_t state_q;
   state_t state_d;
   logic   self_jmp;
   logic   stop_cmd;
   logic   run_cmd;
   logic   step_cmd;
   logic   clear_cmd;
   logic   cnt_clr;
   logic   run_entry;
   logic   bp_hit;

   // Saturating increment for the executed-instruction counter.
   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   prog_store #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_store (
      .clk     (clk),
      .n_reset (n_reset),
      .we      (wr_valid && wr_ready),
      .waddr   (wr_addr),
      .wdata   (wr_data),
      .raddr   (cpu_addr),
      .rdata   (cpu_instr)
   );

   assign run_cmd   = cmd_valid && (cmd == CMD_RUN);
   assign step_cmd  = cmd_valid && (cmd == CMD_STEP);
   assign stop_cmd  = cmd_valid && (cmd == CMD_STOP);
   assign clear_cmd = cmd_valid && (cmd == CMD_CLEAR);

   // A JMP to its own address would spin forever; treat it as program end.
   assign self_jmp = (cpu_instr == {OP_JMP, cpu_addr});

   assign wr_ready = (state_q == ST_IDLE) || (state_q == ST_HALT);
   assign halted   = (state_q == ST_HALT);
   assign state    = state_q;

`ifdef PROG_SEQ_BREAKPOINT_EN
   logic bp_skip;

   // bp_skip lets a resume from HALT execute the instruction sitting on the breakpoint.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bp_skip <= 1'b0;
      end else if (run_entry) begin
         bp_skip <= 1'b1;
      end else if (cpu_en) begin
         bp_skip <= 1'b0;
      end
   end

   assign bp_hit = bp_en && (cpu_addr == bp_addr) && !bp_skip;
`else
   assign bp_hit = 1'b0;
`endif

   // Next-state decode and combinational CPU enable.
   always_comb begin
      state_d   = state_q;
      cpu_en    = 1'b0;
      cnt_clr   = 1'b0;
      run_entry = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_cmd) begin
               state_d = ST_RUN;
            end else if (step_cmd) begin
               state_d = ST_STEP;
            end
         end
         ST_HALT: begin
            if (run_cmd) begin
               state_d   = ST_RUN;
               run_entry = 1'b1;
            end else if (step_cmd) begin
               state_d = ST_STEP;
            end else if (clear_cmd) begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop_cmd || self_jmp || bp_hit) begin
               state_d = ST_HALT;
            end else begin
               cpu_en = 1'b1;
            end
         end
         ST_STEP: begin
            cpu_en  = 1'b1;
            state_d = ST_HALT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Executed-instruction counter: cleared by CLEAR from HALT, saturates at all-ones.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cyc_cnt <= '0;
      end else if (cnt_clr) begin
         cyc_cnt <= '0;
      end else if (cpu_en) begin
         cyc_cnt <= sat_inc(cyc_cnt);
      end
   end

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Directed bench for prog_seq_ctrl: a vector table for the basic
// run/step/clear flow plus hand sequences for saturation, write
// refusal, write+RUN in HALT, async reset and (optionally) breakpoints.
module tb_prog_seq_ctrl;

   logic       clk;
   logic       n_reset;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       wr_valid;
   logic       wr_ready;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] cpu_addr;
   logic [7:0] cpu_instr;
   logic       cpu_en;
   logic [1:0] state;
   logic       halted;
   logic [7:0] cyc_cnt;
`ifdef PROG_SEQ_BREAKPOINT_EN
   logic       bp_en;
   logic [3:0] bp_addr;
`endif

   int n_vec = 0;
   int n_err = 0;

   prog_seq_ctrl dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_addr  (cpu_addr),
      .cpu_instr (cpu_instr),
      .cpu_en    (cpu_en),
      .state     (state),
      .halted    (halted),
      .cyc_cnt   (cyc_cnt)
`ifdef PROG_SEQ_BREAKPOINT_EN
      ,
      .bp_en     (bp_en),
      .bp_addr   (bp_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       cv;
      logic [1:0] c;
      logic       wv;
      logic [3:0] wa;
      logic [7:0] wd;
      logic [3:0] pa;
      logic       e_en;
      logic [1:0] e_st;
      logic       e_rdy;
      logic [7:0] e_ins;
      logic [7:0] e_cyc;
   } vec_t;

   localparam logic [1:0] C_CLR  = 2'b00;
   localparam logic [1:0] C_RUN  = 2'b01;
   localparam logic [1:0] C_STEP = 2'b10;
   localparam logic [1:0] C_STOP = 2'b11;

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic e_en, input logic [1:0] e_st,
                          input logic e_rdy, input logic [7:0] e_ins, input logic [7:0] e_cyc);
      chk("cpu_en", idx, {7'd0, cpu_en}, {7'd0, e_en});
      chk("state", idx, {6'd0, state}, {6'd0, e_st});
      chk("halted", idx, {7'd0, halted}, {7'd0, (e_st == 2'b11)});
      chk("wr_ready", idx, {7'd0, wr_ready}, {7'd0, e_rdy});
      chk("cpu_instr", idx, cpu_instr, e_ins);
      chk("cyc_cnt", idx, cyc_cnt, e_cyc);
   endtask

   // Drive one cycle's inputs just after the falling edge, then settle.
   task automatic drive(input logic cv, input logic [1:0] c, input logic wv,
                        input logic [3:0] wa, input logic [7:0] wd, input logic [3:0] pa);
      @(negedge clk);
      cmd_valid = cv;
      cmd       = c;
      wr_valid  = wv;
      wr_addr   = wa;
      wr_data   = wd;
      cpu_addr  = pa;
      #1;
   endtask

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 2'b00, 1'b1, 8'h00, 8'd0};
      tbl[1]  = '{1'b0, C_CLR,  1'b1, 4'd0, 8'h01, 4'd0, 1'b0, 2'b00, 1'b1, 8'h00, 8'd0};
      tbl[2]  = '{1'b0, C_CLR,  1'b1, 4'd1, 8'hF1, 4'd0, 1'b0, 2'b00, 1'b1, 8'h01, 8'd0};
      tbl[3]  = '{1'b1, C_RUN,  1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 2'b00, 1'b1, 8'hF1, 8'd0};
      tbl[4]  = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd0, 1'b1, 2'b01, 1'b0, 8'h01, 8'd0};
      tbl[5]  = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 2'b01, 1'b0, 8'hF1, 8'd1};
      tbl[6]  = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 2'b11, 1'b1, 8'hF1, 8'd1};
      tbl[7]  = '{1'b1, C_STEP, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 2'b11, 1'b1, 8'hF1, 8'd1};
      tbl[8]  = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd1, 1'b1, 2'b10, 1'b0, 8'hF1, 8'd1};
      tbl[9]  = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 2'b11, 1'b1, 8'hF1, 8'd2};
      tbl[10] = '{1'b1, C_CLR,  1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 2'b11, 1'b1, 8'hF1, 8'd2};
      tbl[11] = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 2'b00, 1'b1, 8'hF1, 8'd0};
      tbl[12] = '{1'b1, C_STOP, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 2'b00, 1'b1, 8'h01, 8'd0};
      tbl[13] = '{1'b1, C_CLR,  1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 2'b00, 1'b1, 8'h01, 8'd0};
      tbl[14] = '{1'b0, C_CLR,  1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 2'b00, 1'b1, 8'h01, 8'd0};

      n_reset   = 1'b0;
      cmd_valid = 1'b0;
      cmd       = 2'b00;
      wr_valid  = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      cpu_addr  = '0;
`ifdef PROG_SEQ_BREAKPOINT_EN
      bp_en     = 1'b0;
      bp_addr   = '0;
`endif

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk_all(100, 1'b0, 2'b00, 1'b1, 8'h00, 8'd0);
      @(negedge clk);
      n_reset = 1'b1;

      // Table: load program, run to self-jump, step, clear, ignored commands
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].cv, tbl[i].c, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].pa);
         chk_all(i, tbl[i].e_en, tbl[i].e_st, tbl[i].e_rdy, tbl[i].e_ins, tbl[i].e_cyc);
      end

      // Saturation run over an all-zero program with a refused write mid-run
      drive(1'b0, C_CLR, 1'b1, 4'd0, 8'h00, 4'd2);
      drive(1'b0, C_CLR, 1'b1, 4'd1, 8'h00, 4'd2);
      drive(1'b1, C_RUN, 1'b0, 4'd0, 8'h00, 4'd2);
      chk_all(200, 1'b0, 2'b00, 1'b1, 8'h00, 8'd0);
      for (int i = 0; i < 300; i++) begin
         if (i == 10) begin
            drive(1'b1, C_RUN, 1'b1, 4'd5, 8'hA5, 4'd2);
            chk_all(201, 1'b1, 2'b01, 1'b0, 8'h00, 8'd10);
         end else begin
            drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd2);
         end
         if (i == 299) begin
            chk_all(202, 1'b1, 2'b01, 1'b0, 8'h00, 8'd255);
         end
      end
      drive(1'b1, C_STOP, 1'b0, 4'd0, 8'h00, 4'd2);
      chk_all(203, 1'b0, 2'b01, 1'b0, 8'h00, 8'd255);
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd5);
      chk_all(204, 1'b0, 2'b11, 1'b1, 8'h00, 8'd255);

      // Write and RUN together in HALT: both land at the same edge
      drive(1'b1, C_RUN, 1'b1, 4'd5, 8'hA5, 4'd5);
      chk_all(205, 1'b0, 2'b11, 1'b1, 8'h00, 8'd255);
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd5);
      chk_all(206, 1'b1, 2'b01, 1'b0, 8'hA5, 8'd255);

      // Asynchronous reset mid-RUN clears everything including the program
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd5);
      n_reset = 1'b0;
      #1;
      chk_all(207, 1'b0, 2'b00, 1'b1, 8'h00, 8'd0);
      @(negedge clk);
      n_reset = 1'b1;

`ifdef PROG_SEQ_BREAKPOINT_EN
      // Breakpoint at address 3: halt before it, resume executes it once
      bp_en   = 1'b1;
      bp_addr = 4'd3;
      drive(1'b1, C_RUN, 1'b0, 4'd0, 8'h00, 4'd0);
      chk_all(300, 1'b0, 2'b00, 1'b1, 8'h00, 8'd0);
      for (int a = 0; a < 3; a++) begin
         drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'(a));
         chk_all(301 + a, 1'b1, 2'b01, 1'b0, 8'h00, 8'(a));
      end
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd3);
      chk_all(304, 1'b0, 2'b01, 1'b0, 8'h00, 8'd3);
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd3);
      chk_all(305, 1'b0, 2'b11, 1'b1, 8'h00, 8'd3);
      drive(1'b1, C_RUN, 1'b0, 4'd0, 8'h00, 4'd3);
      chk_all(306, 1'b0, 2'b11, 1'b1, 8'h00, 8'd3);
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd3);
      chk_all(307, 1'b1, 2'b01, 1'b0, 8'h00, 8'd3);
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd4);
      chk_all(308, 1'b1, 2'b01, 1'b0, 8'h00, 8'd4);
      drive(1'b0, C_CLR, 1'b0, 4'd0, 8'h00, 4'd3);
      chk_all(309, 1'b0, 2'b01, 1'b0, 8'h00, 8'd5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
